// File: rtl/mem_access_arbiter_if.sv
// Host request/response and memory bus signals shared between the arbiter and its environment.
// The slave modport is the arbiter's view; the master modport is the host/memory side.
interface mem_access_arbiter_if #(
    parameter int unsigned N_BANKS = 20
);
    logic               i_host_req;
    logic [4:0]         i_host_bank;
    logic [7:0]         i_host_addr;
    logic               i_host_sel;
    logic               o_host_valid;
    logic [7:0]         o_host_data;
    logic [N_BANKS-1:0] o_mem_cs;
    logic [7:0]         o_mem_addr;
    logic               o_mem_sel;
    logic [7:0]         i_mem_data;

    modport slave (
        input  i_host_req, i_host_bank, i_host_addr, i_host_sel, i_mem_data,
        output o_host_valid, o_host_data, o_mem_cs, o_mem_addr, o_mem_sel
    );

    modport master (
        output i_host_req, i_host_bank, i_host_addr, i_host_sel, i_mem_data,
        input  o_host_valid, o_host_data, o_mem_cs, o_mem_addr, o_mem_sel
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Arbitrates single-byte memory reads between a host port and a background pattern scanner.
// Host has strict priority; the scanner walks {bank, addr, sel} and counts pattern mismatches.
module mem_access_arbiter #(
    parameter int unsigned N_BANKS = 20,
    parameter logic [7:0]  PATTERN = 8'h55
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    mem_access_arbiter_if.slave    bus,
    input  logic                   i_scan_en,
    input  logic                   i_clr_err,
    output logic [15:0]            o_err_count,
    output logic [15:0]            o_pass_count,
    output logic                   o_scan_done
);

    typedef enum logic [2:0] {
        StIdle,
        StHostRd,
        StHostRsp,
        StScanRd,
        StScanCmp
    } state_t;

    state_t             r_state;
    logic [N_BANKS-1:0] r_mem_cs;
    logic [7:0]         r_mem_addr;
    logic               r_mem_sel;
    logic               r_host_valid;
    logic [7:0]         r_host_data;
    logic               r_host_bad;
    logic [7:0]         r_scan_data;
    logic [4:0]         r_ptr_bank;
    logic [7:0]         r_ptr_addr;
    logic               r_ptr_sel;
    logic [15:0]        r_err_count;
    logic [15:0]        r_pass_count;
    logic               r_scan_done;

    logic [N_BANKS-1:0] w_host_cs;
    logic [N_BANKS-1:0] w_scan_cs;
    logic               w_host_ok;
    logic [7:0]         w_expected;
    logic               w_mismatch;
    logic               w_last_bank;

    always_comb begin
        w_host_cs = '0;
        w_scan_cs = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            w_host_cs[b] = (i_host_bank_eq(b));
            w_scan_cs[b] = (r_ptr_bank == 5'(b));
        end
    end

    function automatic logic i_host_bank_eq(input int b);
        return bus.i_host_bank == 5'(b);
    endfunction

    assign w_host_ok   = 32'(bus.i_host_bank) < N_BANKS;
    assign w_expected  = r_ptr_sel ? ~PATTERN : PATTERN;
    assign w_mismatch  = (r_scan_data != w_expected);
    assign w_last_bank = (32'(r_ptr_bank) == N_BANKS - 1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_mem_cs     <= '0;
            r_mem_addr   <= '0;
            r_mem_sel    <= 1'b0;
            r_host_valid <= 1'b0;
            r_host_data  <= '0;
            r_host_bad   <= 1'b0;
            r_scan_data  <= '0;
            r_ptr_bank   <= '0;
            r_ptr_addr   <= '0;
            r_ptr_sel    <= 1'b0;
            r_err_count  <= '0;
            r_pass_count <= '0;
            r_scan_done  <= 1'b0;
        end else begin
            r_host_valid <= 1'b0;
            r_scan_done  <= 1'b0;

            // Clear beats a same-cycle mismatch increment.
            if (i_clr_err) begin
                r_err_count <= '0;
            end else if (r_state == StScanCmp && w_mismatch && r_err_count != 16'hFFFF) begin
                r_err_count <= r_err_count + 16'd1;
            end

            case (r_state)
                StIdle: begin
                    if (bus.i_host_req) begin
                        r_state    <= StHostRd;
                        r_mem_cs   <= w_host_cs;
                        r_mem_addr <= bus.i_host_addr;
                        r_mem_sel  <= bus.i_host_sel;
                        r_host_bad <= !w_host_ok;
                    end else if (i_scan_en) begin
                        r_state    <= StScanRd;
                        r_mem_cs   <= w_scan_cs;
                        r_mem_addr <= r_ptr_addr;
                        r_mem_sel  <= r_ptr_sel;
                    end
                end
                StHostRd: begin
                    r_state      <= StHostRsp;
                    r_mem_cs     <= '0;
                    r_host_valid <= 1'b1;
                    r_host_data  <= r_host_bad ? 8'hFF : bus.i_mem_data;
                end
                StHostRsp: begin
                    r_state <= StIdle;
                end
                StScanRd: begin
                    r_state     <= StScanCmp;
                    r_mem_cs    <= '0;
                    r_scan_data <= bus.i_mem_data;
                end
                StScanCmp: begin
                    r_state <= StIdle;
                    if (!r_ptr_sel) begin
                        r_ptr_sel <= 1'b1;
                    end else begin
                        r_ptr_sel  <= 1'b0;
                        r_ptr_addr <= r_ptr_addr + 8'd1;
                        if (r_ptr_addr == 8'hFF) begin
                            if (w_last_bank) begin
                                r_ptr_bank   <= '0;
                                r_scan_done  <= 1'b1;
                                r_pass_count <= r_pass_count + 16'd1;
                            end else begin
                                r_ptr_bank <= r_ptr_bank + 5'd1;
                            end
                        end
                    end
                end
                default: begin
                    r_state  <= StIdle;
                    r_mem_cs <= '0;
                end
            endcase
        end
    end

    assign bus.o_mem_cs     = r_mem_cs;
    assign bus.o_mem_addr   = r_mem_addr;
    assign bus.o_mem_sel    = r_mem_sel;
    assign bus.o_host_valid = r_host_valid;
    assign bus.o_host_data  = r_host_data;
    assign o_err_count      = r_err_count;
    assign o_pass_count     = r_pass_count;
    assign o_scan_done      = r_scan_done;

endmodule
